// File: rtl/crtc_mode_loader_if.sv
// Bus bundle for the CRTC mode loader: CPU side, CRTC side and loader status.
interface crtc_mode_loader_if;
  logic [1:0] mode_sel;
  logic       mode_load;
  logic       vblank;
  logic       cpu_en;
  logic       cpu_r_nw;
  logic       cpu_rs;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic [7:0] crtc_di;
  logic       crtc_enable;
  logic       crtc_ncs;
  logic       crtc_r_nw;
  logic       crtc_rs;
  logic [7:0] crtc_do;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output mode_sel, mode_load, vblank, cpu_en, cpu_r_nw, cpu_rs, cpu_di, crtc_di,
    input  cpu_do, crtc_enable, crtc_ncs, crtc_r_nw, crtc_rs, crtc_do, busy, done, overrun
  );

  modport slave (
    input  mode_sel, mode_load, vblank, cpu_en, cpu_r_nw, cpu_rs, cpu_di, crtc_di,
    output cpu_do, crtc_enable, crtc_ncs, crtc_r_nw, crtc_rs, crtc_do, busy, done, overrun
  );
endinterface

// File: rtl/crtc_mode_loader.sv
// Loads one of four CRTC register sets (R0..R11) while arbitrating CPU access to the CRTC.
// state   | meaning
// IDLE    | CPU owns the CRTC bus (pass-through)
// WAIT_VB | load latched, waiting for a vblank rising edge
// ADDR    | sequencer writes index register with idx
// DATA    | sequencer writes table[mode][idx]
// RESTORE | sequencer restores the CPU's index register from the shadow
// DRAIN   | sequencer replays the held CPU write
module crtc_mode_loader #(
  parameter bit SYNC_VBLANK = 1'b1
) (
  input logic           CLOCK,
  input logic           RESET,
  crtc_mode_loader_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_VB = 3'd1;
  localparam logic [2:0] ADDR    = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] RESTORE = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;

  // One row per mode, R0 in the top byte.
  localparam logic [95:0] TBL [4] = '{
    96'h38282D0A1F06191C02070607,
    96'h71505A0A1F06191C02070607,
    96'h38282D0A7F06647002010607,
    96'h6150520F19061919020D0B0C
  };

  logic [2:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] mode_q, mode_d;
  logic [4:0] shadow_q, shadow_d;
  logic       pend_q, pend_d;
  logic       hold_rs_q, hold_rs_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       overrun_q, overrun_d;
  logic       done_q, done_d;
  logic       vb_q;

  logic        busy;
  logic        cpu_wr;
  logic        hold_take;
  logic [3:0]  rem;
  logic [95:0] row;
  logic [7:0]  tbl_val;

  assign busy      = (state_q != IDLE);
  assign cpu_wr    = bus.cpu_en & ~bus.cpu_r_nw;
  // The drain cycle frees the slot, so a write landing there refills it.
  assign hold_take = busy & cpu_wr & ((state_q == DRAIN) | ~pend_q);
  assign rem       = 4'd11 - idx_q;
  assign row       = TBL[mode_q] >> {rem, 3'b000};
  assign tbl_val   = row[7:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    hold_rs_d   = hold_rs_q;
    hold_data_d = hold_data_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;

    if (cpu_wr & ~bus.cpu_rs) shadow_d = bus.cpu_di[4:0];

    case (state_q)
      IDLE: begin
        if (bus.mode_load) begin
          mode_d  = bus.mode_sel;
          idx_d   = 4'd0;
          state_d = SYNC_VBLANK ? WAIT_VB : ADDR;
        end
      end
      WAIT_VB: if (!vb_q && bus.vblank) state_d = ADDR;
      ADDR:    state_d = DATA;
      DATA: begin
        if (idx_q == 4'd11) state_d = RESTORE;
        else begin
          idx_d   = idx_q + 4'd1;
          state_d = ADDR;
        end
      end
      RESTORE: begin
        if (pend_q | hold_take) state_d = DRAIN;
        else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        pend_d  = 1'b0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (hold_take) begin
      pend_d      = 1'b1;
      hold_rs_d   = bus.cpu_rs;
      hold_data_d = bus.cpu_di;
    end else if (busy & cpu_wr) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      mode_q      <= 2'd0;
      shadow_q    <= 5'd0;
      pend_q      <= 1'b0;
      hold_rs_q   <= 1'b0;
      hold_data_q <= 8'd0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      vb_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      hold_rs_q   <= hold_rs_d;
      hold_data_q <= hold_data_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      vb_q        <= bus.vblank;
    end
  end

  logic       en_c, ncs_c, rnw_c, rs_c;
  logic [7:0] do_c;

  always_comb begin
    en_c  = 1'b0;
    ncs_c = 1'b1;
    rnw_c = 1'b1;
    rs_c  = 1'b0;
    do_c  = 8'd0;
    case (state_q)
      IDLE: begin
        en_c  = bus.cpu_en;
        ncs_c = ~bus.cpu_en;
        rnw_c = bus.cpu_r_nw;
        rs_c  = bus.cpu_rs;
        do_c  = bus.cpu_di;
      end
      ADDR:    begin en_c = 1'b1; ncs_c = 1'b0; rnw_c = 1'b0; rs_c = 1'b0;      do_c = {4'd0, idx_q}; end
      DATA:    begin en_c = 1'b1; ncs_c = 1'b0; rnw_c = 1'b0; rs_c = 1'b1;      do_c = tbl_val; end
      RESTORE: begin en_c = 1'b1; ncs_c = 1'b0; rnw_c = 1'b0; rs_c = 1'b0;      do_c = {3'd0, shadow_q}; end
      DRAIN:   begin en_c = 1'b1; ncs_c = 1'b0; rnw_c = 1'b0; rs_c = hold_rs_q; do_c = hold_data_q; end
      default: ;
    endcase
  end

  assign bus.crtc_enable = en_c;
  assign bus.crtc_ncs    = ncs_c;
  assign bus.crtc_r_nw   = rnw_c;
  assign bus.crtc_rs     = rs_c;
  assign bus.crtc_do     = do_c;
  assign bus.cpu_do      = busy ? 8'hFF : bus.crtc_di;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_crtc_mode_loader.sv
// Scoreboard bench: stimulus pushes expected sequencer bus writes, a monitor pops and compares them.
module tb_crtc_mode_loader;
  logic CLOCK = 1'b0;
  logic RESET;
  always #5 CLOCK = ~CLOCK;

  crtc_mode_loader_if b0();
  crtc_mode_loader_if b1();

  crtc_mode_loader #(.SYNC_VBLANK(1'b0)) u0 (.CLOCK(CLOCK), .RESET(RESET), .bus(b0));
  crtc_mode_loader #(.SYNC_VBLANK(1'b1)) u1 (.CLOCK(CLOCK), .RESET(RESET), .bus(b1));

  int checks   = 0;
  int failures = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  logic [7:0] tbl [4][12] = '{
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07},
    '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19, 8'h02, 8'h0D, 8'h0B, 8'h0C}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Pushes {rs,data} pairs for idx 0..last of a mode.
  task automatic push_regs(input int which, input int m, input int last);
    for (int i = 0; i <= last; i++) begin
      if (which == 0) begin
        q0.push_back({1'b0, 4'd0, i[3:0]});
        q0.push_back({1'b1, tbl[m][i]});
      end else begin
        q1.push_back({1'b0, 4'd0, i[3:0]});
        q1.push_back({1'b1, tbl[m][i]});
      end
    end
  endtask

  task automatic wait_done0(input int start_k, output int at);
    at = -1;
    for (int k = start_k + 1; k < start_k + 60; k++) begin
      tick();
      if (b0.done) begin
        at = k;
        break;
      end
    end
  endtask

  always @(negedge CLOCK) begin
    if (b0.busy && b0.crtc_enable && !b0.crtc_ncs && !b0.crtc_r_nw) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u0_unexpected_write: got rs=%0b do=%0h expected none", b0.crtc_rs, b0.crtc_do);
      end else begin
        logic [8:0] e;
        e = q0.pop_front();
        chk("u0_bus_write", {b0.crtc_rs, b0.crtc_do}, e);
      end
    end
    if (b1.busy && b1.crtc_enable && !b1.crtc_ncs && !b1.crtc_r_nw) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u1_unexpected_write: got rs=%0b do=%0h expected none", b1.crtc_rs, b1.crtc_do);
      end else begin
        logic [8:0] e;
        e = q1.pop_front();
        chk("u1_bus_write", {b1.crtc_rs, b1.crtc_do}, e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_at, at;
    b0.mode_sel = 0; b0.mode_load = 0; b0.vblank = 0; b0.cpu_en = 0;
    b0.cpu_r_nw = 1; b0.cpu_rs = 0; b0.cpu_di = 0; b0.crtc_di = 0;
    b1.mode_sel = 0; b1.mode_load = 0; b1.vblank = 0; b1.cpu_en = 0;
    b1.cpu_r_nw = 1; b1.cpu_rs = 0; b1.cpu_di = 0; b1.crtc_di = 0;
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    chk("reset_busy", b0.busy, 0);
    chk("reset_done", b0.done, 0);
    chk("reset_overrun", b0.overrun, 0);

    // IDLE pass-through
    b0.cpu_en = 1; b0.cpu_r_nw = 1; b0.cpu_rs = 1; b0.cpu_di = 8'h5A; b0.crtc_di = 8'h3C;
    #1;
    chk("pt_enable", b0.crtc_enable, 1);
    chk("pt_ncs", b0.crtc_ncs, 0);
    chk("pt_rnw", b0.crtc_r_nw, 1);
    chk("pt_rs", b0.crtc_rs, 1);
    chk("pt_do", b0.crtc_do, 8'h5A);
    chk("pt_cpu_do", b0.cpu_do, 8'h3C);
    b0.cpu_en = 0;
    tick();

    // Mode 1 load, immediate start; a second request and mode change mid-load are ignored
    push_regs(0, 1, 11);
    q0.push_back(9'h000);
    b0.mode_sel = 1; b0.mode_load = 1;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) b0.mode_load = 0;
      if (k == 3) begin
        b0.cpu_en = 1; b0.cpu_r_nw = 1; b0.cpu_rs = 1;
        #1;
        chk("busy_read_cpu_do", b0.cpu_do, 8'hFF);
        chk("busy_read_rnw", b0.crtc_r_nw, 0);
      end
      if (k == 4) b0.cpu_en = 0;
      if (k == 5) begin b0.mode_load = 1; b0.mode_sel = 3; end
      if (k == 6) b0.mode_load = 0;
      if (b0.busy) busy_cnt++;
      if (b0.done) begin done_cnt++; done_at = k; end
    end
    chk("load1_busy_cycles", busy_cnt, 25);
    chk("load1_done_cycle", done_at, 26);
    chk("load1_done_pulses", done_cnt, 1);
    chk("load1_queue_empty", q0.size(), 0);

    // Index 0x0E before load, one held data write drained after RESTORE
    b0.cpu_en = 1; b0.cpu_r_nw = 0; b0.cpu_rs = 0; b0.cpu_di = 8'h0E;
    tick();
    b0.cpu_en = 0;
    push_regs(0, 0, 11);
    q0.push_back(9'h00E);
    q0.push_back(9'h112);
    b0.mode_sel = 0; b0.mode_load = 1;
    tick();
    b0.mode_load = 0;
    repeat (3) tick();
    b0.cpu_en = 1; b0.cpu_r_nw = 0; b0.cpu_rs = 1; b0.cpu_di = 8'h12;
    tick();
    b0.cpu_en = 0;
    wait_done0(5, at);
    chk("drain_done_cycle", at, 27);
    chk("drain_overrun", b0.overrun, 0);

    // Two writes during one load: first drained, second dropped
    push_regs(0, 2, 11);
    q0.push_back(9'h00E);
    q0.push_back(9'h1A1);
    b0.mode_sel = 2; b0.mode_load = 1;
    tick();
    b0.mode_load = 0;
    repeat (3) tick();
    b0.cpu_en = 1; b0.cpu_r_nw = 0; b0.cpu_rs = 1; b0.cpu_di = 8'hA1;
    tick();
    b0.cpu_en = 0;
    repeat (3) tick();
    b0.cpu_en = 1; b0.cpu_di = 8'hB2;
    tick();
    b0.cpu_en = 0;
    wait_done0(9, at);
    chk("overrun_done_cycle", at, 27);
    chk("overrun_set", b0.overrun, 1);
    repeat (5) tick();
    chk("overrun_sticky", b0.overrun, 1);
    RESET = 1;
    tick();
    RESET = 0;
    chk("overrun_cleared", b0.overrun, 0);

    // Reset during DATA of idx 5, then a fresh mode 3 load
    push_regs(0, 0, 5);
    b0.mode_sel = 0; b0.mode_load = 1;
    tick();
    b0.mode_load = 0;
    repeat (11) tick();
    chk("mid_data_rs", b0.crtc_rs, 1);
    chk("mid_data_do", b0.crtc_do, 8'h06);
    RESET = 1;
    tick();
    b0.cpu_en = 1; b0.cpu_r_nw = 0; b0.cpu_rs = 1; b0.cpu_di = 8'h77;
    #1;
    chk("rst_busy", b0.busy, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_pt_enable", b0.crtc_enable, 1);
    chk("rst_pt_rs", b0.crtc_rs, 1);
    chk("rst_pt_do", b0.crtc_do, 8'h77);
    b0.cpu_en = 0;
    RESET = 0;
    tick();
    push_regs(0, 3, 11);
    q0.push_back(9'h000);
    b0.mode_sel = 3; b0.mode_load = 1;
    tick();
    b0.mode_load = 0;
    wait_done0(1, at);
    chk("restart_done_cycle", at, 26);

    // vblank-synchronised load requested while vblank is already high
    b1.vblank = 1;
    repeat (2) tick();
    b1.mode_sel = 3; b1.mode_load = 1;
    tick();
    b1.mode_load = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("vb_wait_busy", b1.busy, 1);
      chk("vb_wait_idle_bus", b1.crtc_enable, 0);
    end
    b1.vblank = 0;
    repeat (2) tick();
    push_regs(1, 3, 11);
    q1.push_back(9'h000);
    b1.vblank = 1;
    #1;
    chk("vb_edge_no_write_yet", b1.crtc_enable, 0);
    tick();
    chk("vb_first_addr_en", b1.crtc_enable, 1);
    chk("vb_first_addr_rs", b1.crtc_rs, 0);
    chk("vb_first_addr_do", b1.crtc_do, 8'h00);
    done_at = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (b1.done) begin done_at = k; break; end
    end
    chk("vb_done_seen", done_at, 24);

    tick();
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crtc_mode_loader.md
CRTC_MODE_LOADER -- requirements
Module: crtc_mode_loader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; the ports are named CLOCK and RESET.
REQ-002 Parameter list, one per line: SYNC_VBLANK, default 1, meaning 1 = a load starts only at a vblank rising edge and 0 = a load starts immediately.
REQ-003 Port list, one per line: name, direction, width, meaning.
- CLOCK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- mode_sel  in  2  table select: 0=CGA40, 1=CGA80, 2=CGA gfx, 3=MDA
- mode_load  in  1  one-cycle load request
- vblank  in  1  CRTC vblank (level)
- cpu_en  in  1  CPU CRTC access strobe
- cpu_r_nw  in  1  CPU 1=read, 0=write
- cpu_rs  in  1  CPU register select (0=index, 1=data)
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data
- crtc_di  in  8  CRTC DO readback
- crtc_enable  out  1  CRTC ENABLE
- crtc_ncs  out  1  CRTC nCS
- crtc_r_nw  out  1  CRTC R_nW
- crtc_rs  out  1  CRTC RS
- crtc_do  out  8  CRTC DI
- busy  out  1  sequencer owns the CRTC bus
- done  out  1  one-cycle pulse when a load completes
- overrun  out  1  sticky flag: a CPU write was dropped

Function
REQ-004 FSM states SHALL be IDLE, WAIT_VB, ADDR, DATA, RESTORE, DRAIN.
REQ-005 In IDLE, the block SHALL pass CPU signals combinationally: crtc_enable=cpu_en, crtc_ncs=~cpu_en, crtc_r_nw=cpu_r_nw, crtc_rs=cpu_rs, crtc_do=cpu_di, cpu_do=crtc_di.
REQ-006 A CPU index write in any state (cpu_en & ~cpu_r_nw & ~cpu_rs) SHALL update the 5-bit shadow with cpu_di[4:0], even when that write is held.
REQ-007 When mode_load is high in IDLE, the block SHALL latch mode_sel and go to WAIT_VB if SYNC_VBLANK=1, otherwise to ADDR with idx=0.
REQ-008 WAIT_VB SHALL go to ADDR on the cycle after vblank is sampled 0 and then 1 (rising edge); a load requested while vblank is already high SHALL wait for the next rising edge.
REQ-009 ADDR SHALL drive enable=1, ncs=0, r_nw=0, rs=0, do={3'b0,idx}, then go to DATA.
REQ-010 DATA SHALL drive enable=1, ncs=0, r_nw=0, rs=1, do=table[mode][idx]; if idx=11 it SHALL go to RESTORE, otherwise idx+1 and go to ADDR.
REQ-011 RESTORE SHALL drive an index write with do={3'b0,shadow}, then go to DRAIN if a write is pending, otherwise to IDLE.
REQ-012 DRAIN SHALL issue the held write (rs, data) with enable=1, ncs=0, r_nw=0, clear pending, then go to IDLE.
REQ-013 done SHALL pulse for exactly one cycle, on the cycle the FSM enters IDLE from RESTORE or DRAIN.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 While busy is 1, outside the DRAIN/RESTORE/ADDR/DATA drive: crtc_enable=0, crtc_ncs=1, crtc_r_nw=1, crtc_rs=0, crtc_do=0.
REQ-016 CPU reads while busy SHALL return cpu_do=8'hFF.
REQ-017 A CPU write while busy SHALL go into a one-entry hold slot (rs, data); if the slot is full, the write SHALL be dropped and overrun set to 1.
REQ-018 A write arriving in the DRAIN cycle SHALL refill the slot; a load takes 24 register cycles plus RESTORE, plus optional DRAIN.
REQ-019 mode_load while busy SHALL be ignored; mode_sel changes while busy SHALL have no effect.
REQ-020 Tables for R0..R11, hex:
- mode 0: 38 28 2D 0A 1F 06 19 1C 02 07 06 07
- mode 1: 71 50 5A 0A 1F 06 19 1C 02 07 06 07
- mode 2: 38 28 2D 0A 7F 06 64 70 02 01 06 07
- mode 3: 61 50 52 0F 19 06 19 19 02 0D 0B 0C
REQ-021 R12 to R15 SHALL never be written by the sequencer.

Reset
REQ-022 RESET high SHALL, on the next CLOCK edge, force IDLE with idx=0, shadow=0, pending=0, overrun=0, done=0, busy=0, including mid-load; the CRTC bus then reflects CPU pass-through.

Verification
REQ-023 SYNC_VBLANK=0, mode_sel=1, mode_load pulse -> 24 alternating writes: (rs0,00),(rs1,71),(rs0,01),(rs1,50) ... (rs0,0B),(rs1,07), then RESTORE (rs0,00); done on cycle 26 after the request; busy high for 25 cycles.
REQ-024 CPU writes index 0x0E before the load, then writes data 0x12 during the load -> RESTORE drives 0x0E, DRAIN drives (rs1,0x12), overrun=0.
REQ-025 Two CPU writes during one load -> the first is drained, the second is dropped, overrun=1 until RESET.
REQ-026 SYNC_VBLANK=1, vblank held high at the request -> no CRTC write until vblank goes 0 then 1; the first ADDR comes one cycle after the rising edge.
REQ-027 RESET asserted during DATA of idx 5 -> next cycle busy=0, done=0, outputs follow the CPU; a new mode_load=3 restarts from idx 0 with value 61.
REQ-028 CPU read while busy -> cpu_do=FF and crtc_r_nw stays 0/1 per the sequencer, never the CPU.
